// File: rtl/alu_pkg.sv
// Shared types for the accumulator controller.
// Data width, ALU opcode encodings and controller FSM states.
package alu_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_acc_ctrl.sv
// Accumulator controller driving an external ALU / result mux.
// Define ALU_ACC_CTRL_OPCNT_EN to add the saturating op_cnt output.
module alu_acc_ctrl
    import alu_pkg::*;
#(
    parameter logic [DATA_W-1:0] ACC_RESET = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_ACC_CTRL_OPCNT_EN
    output logic [7:0]        op_cnt,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_load,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero
);

    state_e              r_state;
    state_e              w_next;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_b;
    alu_op_e             r_sel;
    logic                w_xfer;

    assign cmd_ready = (r_state == ST_IDLE);
    assign res_valid = (r_state == ST_RESP);
    assign w_xfer    = cmd_valid & cmd_ready;

    assign alu_a     = r_acc;
    assign alu_b     = r_b;
    assign alu_sel   = r_sel;
    assign res_data  = r_acc;
    assign res_zero  = (r_acc == '0);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer)
                    w_next = cmd_load ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: begin
                if (res_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Operand registers stay frozen after capture so the external
    // ALU sees stable inputs for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b   <= '0;
            r_sel <= OP_ADD;
        end else if (w_xfer) begin
            r_b   <= cmd_data;
            r_sel <= alu_op_e'(cmd_op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= ACC_RESET;
        else if (w_xfer && cmd_load)
            r_acc <= cmd_data;
        else if (r_state == ST_EXEC)
            r_acc <= alu_out;
    end

`ifdef ALU_ACC_CTRL_OPCNT_EN
    logic [7:0] r_cnt;
    logic       w_res_hs;

    assign w_res_hs = res_valid & res_ready;
    assign op_cnt   = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_res_hs && (r_cnt != 8'hFF))
            r_cnt <= r_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Randomized self-checking bench for alu_acc_ctrl with an
// arithmetic reference model and a behavioural external ALU.
module tb_alu_acc_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_load;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
`ifdef ALU_ACC_CTRL_OPCNT_EN
    logic [7:0] op_cnt;
`endif

    int n_vec;
    int n_err;
    int acc_m;
    int hs_m;

    alu_acc_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef ALU_ACC_CTRL_OPCNT_EN
        .op_cnt   (op_cnt),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_load (cmd_load),
        .cmd_data (cmd_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_zero (res_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4:1 result mux fed by the four ALU operators.
    always_comb begin
        alu_out = 4'h0;
        case (alu_sel)
            2'b00: alu_out = alu_a + alu_b;
            2'b01: alu_out = alu_a - alu_b;
            2'b10: alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_op(input int a, input int op, input int b);
        int r;
        case (op)
            0: r = (a + b) % 16;
            1: r = (a - b + 16) % 16;
            2: r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_cmd(input logic ld, input logic [1:0] op,
                          input logic [3:0] d, input int hold);
        int exp;
        exp = ld ? int'(d) : ref_op(acc_m, int'(op), int'(d));
        check("idle_rdy", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = 4'($urandom);
        cmd_op    = 2'($urandom);
        if (!ld) begin
            check("exec_nv", int'(res_valid), 0);
            check("exec_rdy", int'(cmd_ready), 0);
            check("exec_a", int'(alu_a), acc_m);
            check("exec_b", int'(alu_b), int'(d));
            check("exec_sel", int'(alu_sel), int'(op));
            @(posedge clk); #1;
        end
        acc_m = exp;
        check("res_valid", int'(res_valid), 1);
        check("res_data", int'(res_data), exp);
        check("res_zero", int'(res_zero), (exp == 0) ? 1 : 0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_load  = 1'($urandom);
            cmd_data  = 4'($urandom);
            @(posedge clk); #1;
            check("hold_valid", int'(res_valid), 1);
            check("hold_data", int'(res_data), exp);
            check("hold_rdy", int'(cmd_ready), 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        hs_m++;
        check("done_nv", int'(res_valid), 0);
        check("done_rdy", int'(cmd_ready), 1);
        check("done_acc", int'(alu_a), exp);
`ifdef ALU_ACC_CTRL_OPCNT_EN
        check("op_cnt", int'(op_cnt), sat_cnt(hs_m));
`endif
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        acc_m     = 0;
        hs_m      = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_load  = 1'b0;
        cmd_data  = 4'h0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_rdy", int'(cmd_ready), 1);
        check("rst_valid", int'(res_valid), 0);
        check("rst_data", int'(res_data), 0);
        check("rst_zero", int'(res_zero), 1);
        check("rst_b", int'(alu_b), 0);
        check("rst_sel", int'(alu_sel), 0);
`ifdef ALU_ACC_CTRL_OPCNT_EN
        check("rst_cnt", int'(op_cnt), 0);
`endif

        do_cmd(1'b1, 2'b00, 4'h9, 0);
        do_cmd(1'b0, 2'b00, 4'h8, 0);
        do_cmd(1'b1, 2'b00, 4'h3, 0);
        do_cmd(1'b0, 2'b01, 4'h3, 0);
        do_cmd(1'b0, 2'b11, 4'hA, 0);
        do_cmd(1'b0, 2'b10, 4'h6, 0);
        do_cmd(1'b0, 2'b00, 4'h7, 5);

        // Reset during EXEC of ADD 5 discards the command.
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("pre_rst_exec", int'(cmd_ready), 0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(res_valid), 0);
        check("arst_acc", int'(res_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        acc_m = 0;
        hs_m  = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_nv", int'(res_valid), 0);
            check("post_rst_rdy", int'(cmd_ready), 1);
            check("post_rst_acc", int'(alu_a), 0);
        end
`ifdef ALU_ACC_CTRL_OPCNT_EN
        check("post_rst_cnt", int'(op_cnt), 0);
`endif

        for (int i = 0; i < 300; i++)
            do_cmd($urandom_range(0, 3) == 0, 2'($urandom),
                   4'($urandom), int'($urandom_range(0, 2)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
